// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 definitions for the compression core.
//   T_LO / T_HI : round constants Tj for rounds 0..15 and 16..63
//   IV          : standard SM3 initial chaining value (A..H, A in the MSBs)
//   state_t     : compression FSM states
//   rotl32, P0, P1, FF, GG : SM3 word-level helper functions
package sm3_pkg;

    localparam logic [31:0]  T_LO = 32'h79CC4519;
    localparam logic [31:0]  T_HI = 32'h7A879D8A;
    localparam logic [255:0] IV   = 256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // A rotate by 0 shifts right by 32, which yields zero, so n = 0 is safe.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - 6'(n)));
    endfunction

    function automatic logic [31:0] P0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    function automatic logic [31:0] P1(input logic [31:0] x);
        return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
    endfunction

    // lo = 1 selects the XOR form used in rounds 0..15.
    function automatic logic [31:0] FF(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lo);
        return lo ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] GG(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lo);
        return lo ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

endpackage

// File: rtl/sm3_msg_exp.sv
// sm3_msg_exp: on-the-fly SM3 message expansion as a 16-word sliding window.
//   clk      in  1    clock, rising edge
//   rst      in  1    asynchronous active-high reset, clears the window
//   load     in  1    load window from block_in (word 0 = bits [511:480])
//   shift    in  1    advance one round: W[k] <= W[k+1], W[15] <= next word
//   block_in in  512  message block
//   wj       out 32   Wj  = W[0]
//   wj_p     out 32   W'j = W[0] ^ W[4]
module sm3_msg_exp
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  wj,
    output logic [31:0]  wj_p
);

    logic [31:0] w [16];
    logic [31:0] w_new;

    // W[0] holds W(j), so W[3], W[7], W[10], W[13] are W(j+3) .. W(j+13)
    // and w_new is W(j+16).
    always_comb begin
        w_new = P1(w[0] ^ w[7] ^ rotl32(w[13], 5'd15)) ^ rotl32(w[3], 5'd7) ^ w[10];
        wj    = w[0];
        wj_p  = w[0] ^ w[4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) w[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < 16; k++) w[k] <= block_in[511 - 32*k -: 32];
        end else if (shift) begin
            for (int k = 0; k < 15; k++) w[k] <= w[k+1];
            w[15] <= w_new;
        end
    end

endmodule

// File: rtl/sm3_ss1.sv
// sm3_ss1: SS1 rotate-add datapath of one SM3 round (purely combinational).
//   a   in  32  working register A
//   e   in  32  working register E
//   j   in  6   round index 0..63
//   ss1 out 32  ((A<<<12) + E + (Tj<<<(j mod 32))) <<< 7
module sm3_ss1
    import sm3_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] e,
    input  logic [5:0]  j,
    output logic [31:0] ss1
);

    logic [31:0] tj;
    logic [31:0] sum;

    always_comb begin
        tj  = (j < 6'd16) ? T_LO : T_HI;
        sum = rotl32(a, 5'd12) + e + rotl32(tj, j[4:0]);
        ss1 = rotl32(sum, 5'd7);
    end

endmodule

// File: rtl/sm3_compress.sv
// sm3_compress: iterative SM3 compression function, one round per clock.
// Computes V(i+1) = CF(V(i), B(i)) in 65 clocks from the start edge.
//   clk      in  1    clock, rising edge
//   rst      in  1    asynchronous active-high reset
//   start    in  1    load block_in / v_in and begin (honoured only in IDLE)
//   use_iv   in  1    only when SM3_CMP_IV_EN is defined: load the standard IV
//                     instead of v_in
//   block_in in  512  message block, W0 = bits [511:480]
//   v_in     in  256  chaining value, A = bits [255:224] .. H = bits [31:0]
//   busy     out 1    high while rounds 0..63 are executing
//   done     out 1    one-cycle pulse, v_out valid
//   v_out    out 256  next chaining value, held until the next done
// Optional feature macro: SM3_CMP_IV_EN (adds the use_iv input).
module sm3_compress
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SM3_CMP_IV_EN
    input  logic         use_iv,
`endif
    input  logic [511:0] block_in,
    input  logic [255:0] v_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] v_out
);

    state_t       state;
    state_t       state_next;
    logic         accept;

    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [255:0] v;
    logic [5:0]   j;
    logic [255:0] v_load;

    logic [31:0]  ss1;
    logic [31:0]  ss2;
    logic [31:0]  tt1;
    logic [31:0]  tt2;
    logic [31:0]  wj;
    logic [31:0]  wj_p;
    logic         lo;

`ifdef SM3_CMP_IV_EN
    assign v_load = use_iv ? IV : v_in;
`else
    assign v_load = v_in;
`endif

    assign busy = (state == ROUND);

    sm3_ss1 u_ss1 (
        .a   (a),
        .e   (e),
        .j   (j),
        .ss1 (ss1)
    );

    sm3_msg_exp u_msg_exp (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (state == ROUND),
        .block_in (block_in),
        .wj       (wj),
        .wj_p     (wj_p)
    );

    always_comb begin
        lo  = (j < 6'd16);
        ss2 = ss1 ^ rotl32(a, 5'd12);
        tt1 = FF(a, b, c, lo) + d + ss2 + wj_p;
        tt2 = GG(e, f, g, lo) + h + ss1 + wj;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (j == 6'd63) state_next = FINAL;
            end
            FINAL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {a, b, c, d, e, f, g, h} <= '0;
            v     <= '0;
            j     <= '0;
            v_out <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                {a, b, c, d, e, f, g, h} <= v_load;
                v <= v_load;
                j <= '0;
            end else if (state == ROUND) begin
                a <= tt1;
                b <= a;
                c <= rotl32(b, 5'd9);
                d <= c;
                e <= P0(tt2);
                f <= e;
                g <= rotl32(f, 5'd19);
                h <= g;
                // Wraps 63 -> 0 on the last round, ready for the next block.
                j <= j + 6'd1;
            end else if (state == FINAL) begin
                v_out <= {a, b, c, d, e, f, g, h} ^ v;
                done  <= 1'b1;
            end
        end
    end

endmodule
